// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/forwarding control: shadows EX/MEM/WB destination metadata, drives operand selects, stall, bubble and flush.
// stall/bubble_ex/flush_id are combinational; selects are registered at EX entry; everything holds while mem_busy is high.
module ex_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int REG_SEL  = $clog2(NUM_REGS),
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_SEL-1:0] id_rs1,
  input  logic [REG_SEL-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REG_SEL-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               ex_branch_taken,
  input  logic               mem_busy,
  output logic [1:0]         sel_forward1,
  output logic [1:0]         sel_forward2,
  output logic               stall,
  output logic               bubble_ex,
  output logic               flush_id,
  output logic               ex_valid,
  output logic               mem_valid,
  output logic               wb_valid,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  typedef struct packed {
    logic               valid;
    logic [REG_SEL-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } shadow_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  shadow_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_use, take, stall_c, advance;

  // x0 is hard-wired, so a producer targeting it never forwards or stalls.
  function automatic logic hit(input shadow_t p, input logic [REG_SEL-1:0] s, input logic used);
    return p.valid & p.reg_write & used & (s != '0) & (p.rd == s);
  endfunction

  // EX producer that is not a load lands in MEM next cycle; MEM producer lands in WB.
  function automatic logic [1:0] fwd_sel(input logic from_ex, input logic from_mem);
    if (from_ex)       return SEL_MEM;
    else if (from_mem) return SEL_WB;
    else               return SEL_RF;
  endfunction

  always_comb begin
    ex_hit1  = hit(ex_q, id_rs1, id_rs1_used);
    ex_hit2  = hit(ex_q, id_rs2, id_rs2_used);
    mem_hit1 = hit(mem_q, id_rs1, id_rs1_used);
    mem_hit2 = hit(mem_q, id_rs2, id_rs2_used);
    load_use = id_valid & ex_q.mem_read & (ex_hit1 | ex_hit2);
    advance  = ~mem_busy;
    take     = ex_branch_taken & advance;
    stall_c  = load_use & ~take & advance;
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    sel1_d      = sel1_q;
    sel2_d      = sel2_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (take || stall_c || !id_valid) begin
        ex_d   = '0;
        sel1_d = SEL_RF;
        sel2_d = SEL_RF;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        sel1_d = fwd_sel(ex_hit1 & ~ex_q.mem_read, mem_hit1);
        sel2_d = fwd_sel(ex_hit2 & ~ex_q.mem_read, mem_hit2);
      end
    end
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (take && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel1_q      <= SEL_RF;
      sel2_q      <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall        = stall_c;
    bubble_ex    = take | stall_c;
    flush_id     = take;
    sel_forward1 = sel1_q;
    sel_forward2 = sel2_q;
    ex_valid     = ex_q.valid;
    mem_valid    = mem_q.valid;
    wb_valid     = wb_q.valid;
    stall_count  = stall_cnt_q;
    flush_count  = flush_cnt_q;
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: each task drives a short instruction sequence and checks hand-computed controls.
module tb_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken, mem_busy;
  logic [1:0] sel_forward1, sel_forward2;
  logic stall, bubble_ex, flush_id, ex_valid, mem_valid, wb_valid;
  logic [15:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  ex_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .sel_forward1(sel_forward1), .sel_forward2(sel_forward2),
    .stall(stall), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  wire [41:0] all_out = {sel_forward1, sel_forward2, stall, bubble_ex, flush_id,
                         ex_valid, mem_valid, wb_valid, stall_count, flush_count};
  wire [2:0]  ctl     = {stall, bubble_ex, flush_id};
  wire [2:0]  vld     = {ex_valid, mem_valid, wb_valid};
  wire [3:0]  sels    = {sel_forward1, sel_forward2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic drain();
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    tests++; if (all_out !== 42'd0) begin fails++; $display("FAIL reset_async got %h want 0", all_out); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (all_out !== 42'd0) begin fails++; $display("FAIL idle_cycle%0d got %h want 0", i, all_out); end
    end
  endtask

  task automatic test_fwd_mem();
    drain();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);           // add x5,x1,x2
    tick();
    set_id(1, 5, 1, 7, 1, 6, 1, 0);           // add x6,x5,x7
    #1;
    tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL fwd_mem_nostall got %b want 000", ctl); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (sels !== 4'b10_00) begin fails++; $display("FAIL fwd_mem_sel got %b want 1000", sels); end
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL fwd_mem_exv got %b want 1", ex_valid); end
  endtask

  task automatic test_fwd_wb();
    drain();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);           // add x5
    tick();
    set_id(1, 3, 1, 4, 1, 8, 1, 0);           // independent add x8
    tick();
    set_id(1, 7, 1, 5, 1, 6, 1, 0);           // add x6,x7,x5
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (sels !== 4'b00_01) begin fails++; $display("FAIL fwd_wb_sel got %b want 0001", sels); end
    drain();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);           // add x5
    tick();
    set_id(1, 3, 1, 4, 1, 5, 1, 0);           // add x5 again
    tick();
    set_id(1, 7, 1, 5, 1, 6, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (sels !== 4'b00_10) begin fails++; $display("FAIL fwd_prio_sel got %b want 0010", sels); end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);           // lw x5
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);           // add x6,x5,x5
    #1;
    tests++; if (ctl !== 3'b110) begin fails++; $display("FAIL lu_stall got %b want 110", ctl); end
    tick();
    tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL lu_one_cycle got %b want 000", ctl); end
    tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL lu_count got %0d want 1", stall_count); end
    tests++; if (vld !== 3'b010) begin fails++; $display("FAIL lu_bubble_vld got %b want 010", vld); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (sels !== 4'b01_01) begin fails++; $display("FAIL lu_sel got %b want 0101", sels); end
  endtask

  task automatic test_branch_priority();
    drain();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);           // lw x5
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    ex_branch_taken = 1'b1;
    #1;
    tests++; if (ctl !== 3'b011) begin fails++; $display("FAIL br_ctl got %b want 011", ctl); end
    tick();
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (flush_count !== 16'd1) begin fails++; $display("FAIL br_fcount got %0d want 1", flush_count); end
    tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL br_scount got %0d want 1", stall_count); end
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL br_exv got %b want 0", ex_valid); end
  endtask

  task automatic test_x0();
    drain();
    set_id(1, 1, 1, 2, 1, 0, 1, 0);           // writes x0
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0);           // reads x0,x0
    #1;
    tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL x0_ctl got %b want 000", ctl); end
    tick();
    set_id(1, 1, 1, 0, 0, 0, 1, 1);           // lw x0
    tests++; if (sels !== 4'b00_00) begin fails++; $display("FAIL x0_sel got %b want 0000", sels); end
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0);
    #1;
    tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL x0_lu got %b want 000", ctl); end
  endtask

  task automatic test_mem_busy();
    drain();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);           // add x5
    tick();
    set_id(1, 5, 1, 9, 1, 6, 1, 0);           // add x6,x5,x9
    tick();
    set_id(1, 6, 1, 0, 0, 7, 1, 0);
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL busy_ctl%0d got %b want 000", i, ctl); end
      tests++; if ({sels, vld} !== 7'b10_00_110) begin fails++; $display("FAIL busy_hold%0d got %b want 1000110", i, {sels, vld}); end
      tick();
    end
    tests++; if (flush_count !== 16'd1) begin fails++; $display("FAIL busy_fcount got %0d want 1", flush_count); end
    mem_busy = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (vld !== 3'b011) begin fails++; $display("FAIL busy_resume got %b want 011", vld); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);           // lw x5
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_pre_stall got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    tests++; if (all_out !== 42'd0) begin fails++; $display("FAIL rst_mid got %h want 0", all_out); end
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (ctl !== 3'b000) begin fails++; $display("FAIL rst_no_stall got %b want 000", ctl); end
    tick();
    tests++; if ({ex_valid, sels} !== 5'b1_00_00) begin fails++; $display("FAIL rst_restart got %b want 10000", {ex_valid, sels}); end
    tests++; if (stall_count !== 16'd0) begin fails++; $display("FAIL rst_scount got %0d want 0", stall_count); end
  endtask

  initial begin
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_branch_priority();
    test_x0();
    test_mem_busy();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
